grad_window_buf: RTL and testbench
==================================

# grad_window_buf

Line-buffer window generator sitting directly upstream of the non-maximum-suppression stage in the Canny edge path. It accepts a raster stream of gradient magnitudes with quantised angles, one pixel per accepted beat. For every input pixel it emits one zero-padded 3x3 magnitude window, plus the centre pixel's angle, in the packed form the suppression stage consumes. After the last pixel of a frame it self-flushes, so the output frame has exactly WIDTH*HEIGHT windows.

## Interface
- DSIZE, 4, gradient magnitude width
- ANGSIZE, 2, angle code width (00 `|`, 01 `/`, 10 `-`, 11 `\`)
- WIDTH, 640, pixels per line (>= 2)
- HEIGHT, 480, lines per frame (>= 2)

- i_clk  in  1  clock, all logic on rising edge
- i_rst  in  1  reset, asynchronous, active-high
- i_valid  in  1  input beat present
- i_sof  in  1  first pixel of frame; qualified by i_valid
- i_grad  in  DSIZE  gradient magnitude
- i_angle  in  ANGSIZE  gradient angle code
- o_ready  out  1  block accepts input this cycle; a beat is accepted when i_valid && o_ready
- o_valid  out  1  window valid, single-cycle per window
- o_grad  out  DSIZE*9  window, positions 0..8 row-major (0 1 2 / 3 4 5 / 6 7 8), position 0 in the MSBs
- o_angle  out  ANGSIZE  angle of centre (position 4)
- o_eof  out  1  high with the last window of the frame

## Operation
- Raster index of an input is n = r*WIDTH + c. Row counter is clog2(HEIGHT) bits; column counter is clog2(WIDTH) bits. Counters wrap at WIDTH-1 and HEIGHT-1.
- Storage:
  - Two WIDTH-deep line buffers. Line 1 holds magnitude + angle; line 2 holds magnitude only.
  - A 3x3 magnitude shift window.
  - Centre-angle delay.
- Window centred at index n-WIDTH-1 becomes complete when input n is accepted.
- Zero padding: any neighbour with row < 0, row >= HEIGHT, col < 0 or col >= WIDTH reads as 0. Masking uses the output-centre row/col counters, not stored data. Left-edge masking must not pick up data from the previous line.
- FSM states:
  - IDLE: o_ready=1. Accepted beats without i_sof are discarded. A beat with i_sof goes to FILL and is taken as n=0.
  - FILL: accept beats with no output until n = WIDTH. On accepting n = WIDTH, go to RUN.
  - RUN: each accepted beat n emits the window centred at n-WIDTH-1. On accepting n = WIDTH*HEIGHT-1, go to FLUSH.
  - FLUSH: o_ready=0. Emit the remaining WIDTH+1 windows on consecutive cycles; missing bottom-row neighbours are 0. After the last window, go to IDLE.
- o_eof accompanies the window centred at (HEIGHT-1, WIDTH-1).
- Simultaneous events:
  - i_sof with i_valid in FILL or RUN restarts the frame: counters clear, the beat becomes n=0, state goes to FILL, and partial output is abandoned without o_eof.
  - In FLUSH, i_sof is not accepted because o_ready=0. The upstream holds the beat until IDLE.
- Input gaps (i_valid low) stall the window. Emitted window contents are independent of gap pattern.

## Timing
- Reset values:
  - o_valid=0, o_grad=0, o_angle=0, o_eof=0
  - o_ready=1, state IDLE, counters 0
  - Line-buffer contents undefined. They are never output unmasked before being written in the current frame.
- Latency: o_valid, o_grad, o_angle and o_eof are registered. They assert the cycle after the accepting edge of input n (n >= WIDTH+1).
- FLUSH emits one window per cycle. The first flush window comes the cycle after the last input's own window cycle. The flush has no gaps.
- o_ready is derived from state and is low for exactly WIDTH+1 cycles per frame.
- Reset asserted mid-frame or mid-flush:
  - Outputs clear immediately, asynchronously.
  - After release the block is in IDLE and awaits i_sof.

## Test plan
Unless noted, WIDTH=4, HEIGHT=3. Inputs are i_grad = n+1 and i_angle = n%4 for n=0..11, with i_sof on n=0.

- Corner window: first o_valid follows acceptance of n=5. It carries o_grad=36'h000012056 and o_angle=00 (centre (0,0)). Inputs n=0..4 produce no output.
- Right edge: window centred at (0,3) has o_grad=36'h000340780 and o_angle=11. No wrap-in from the next line.
- Flush and EOF: after n=11, o_ready is low for 5 cycles and 5 consecutive windows are emitted. The last one is 36'h780BC0000 with o_eof=1. Total windows = 12, then IDLE.
- Gapped input: repeat the stream with random i_valid gaps. The window sequence must be identical to the gap-free run.
- Restart: assert i_sof at n=6, then send a fresh 12-pixel frame. There is no o_eof for the aborted frame, and the new frame's first window is 36'h000012056.
- Reset mid-FLUSH: assert i_rst during the third flush cycle. All outputs go to 0 and o_ready=1. After release, a new frame produces the correct 12 windows.

Source files
------------

// File: rtl/grad_window_buf.sv
// grad_window_buf: raster gradient stream in (i_valid/i_sof/i_grad/i_angle, o_ready) -> zero-padded 3x3 windows out (o_valid/o_grad/o_angle/o_eof), self-flushing
module grad_window_buf #(
  parameter int DSIZE   = 4,
  parameter int ANGSIZE = 2,
  parameter int WIDTH   = 640,
  parameter int HEIGHT  = 480
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_valid,
  input  logic                 i_sof,
  input  logic [DSIZE-1:0]     i_grad,
  input  logic [ANGSIZE-1:0]   i_angle,
  output logic                 o_ready,
  output logic                 o_valid,
  output logic [DSIZE*9-1:0]   o_grad,
  output logic [ANGSIZE-1:0]   o_angle,
  output logic                 o_eof
);
  localparam int CW = $clog2(WIDTH);
  localparam int RW = $clog2(HEIGHT);
  typedef enum logic [1:0] {IDLE, FILL, RUN, FLUSH} state_t;
  state_t state_q;
  logic [CW-1:0] col_q, ocol_q, c_in;
  logic [RW-1:0] row_q, orow_q, r_in;
  logic [DSIZE+ANGSIZE-1:0] line1_q [WIDTH];
  logic [DSIZE-1:0] line2_q [WIDTH];
  logic [3*DSIZE-1:0] a_q, b_q, nc;
  logic [ANGSIZE-1:0] ang_b_q, mid_ang, a_in, o_angle_q;
  logic [DSIZE-1:0] g_in, top, mid;
  logic [DSIZE*9-1:0] win, o_grad_q;
  logic acc, sof_take, take, flush, step, emit, last_in, last_out, fill_done, col_end;
  logic t_m, b_m, l_m, r_m, o_valid_q, o_eof_q;
  assign o_ready   = state_q != FLUSH;
  assign acc       = i_valid && o_ready;
  assign sof_take  = acc && i_sof;
  assign take      = acc && (state_q != IDLE || i_sof);
  assign flush     = state_q == FLUSH;
  // flush cycles advance the window with phantom zero pixels below the frame
  assign step      = take || flush;
  assign emit      = (state_q == RUN && take && !i_sof) || flush;
  assign c_in      = sof_take ? '0 : col_q;
  assign r_in      = sof_take ? '0 : row_q;
  assign g_in      = flush ? '0 : i_grad;
  assign a_in      = flush ? '0 : i_angle;
  assign {mid, mid_ang} = line1_q[c_in];
  assign top       = line2_q[c_in];
  assign nc        = {top, mid, g_in};
  assign col_end   = c_in == CW'(WIDTH-1);
  assign last_in   = r_in == RW'(HEIGHT-1) && col_end;
  assign fill_done = r_in == RW'(1) && c_in == '0;
  assign last_out  = orow_q == RW'(HEIGHT-1) && ocol_q == CW'(WIDTH-1);
  // padding is decided from the output-centre position, so stale line data never leaks
  assign t_m = orow_q == '0;
  assign b_m = orow_q == RW'(HEIGHT-1);
  assign l_m = ocol_q == '0;
  assign r_m = ocol_q == CW'(WIDTH-1);
  assign win = {
    (t_m || l_m) ? '0 : a_q[3*DSIZE-1:2*DSIZE], t_m ? '0 : b_q[3*DSIZE-1:2*DSIZE], (t_m || r_m) ? '0 : top,
    l_m ? '0 : a_q[2*DSIZE-1:DSIZE], b_q[2*DSIZE-1:DSIZE], r_m ? '0 : mid,
    (b_m || l_m) ? '0 : a_q[DSIZE-1:0], b_m ? '0 : b_q[DSIZE-1:0], (b_m || r_m) ? '0 : g_in};
  assign o_valid = o_valid_q;
  assign o_grad  = o_grad_q;
  assign o_angle = o_angle_q;
  assign o_eof   = o_eof_q;
  always_ff @(posedge i_clk) begin
    if (step) begin
      line1_q[c_in] <= {g_in, a_in};
      line2_q[c_in] <= mid;
    end
  end
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= IDLE;
      col_q     <= '0;
      row_q     <= '0;
      ocol_q    <= '0;
      orow_q    <= '0;
      a_q       <= '0;
      b_q       <= '0;
      ang_b_q   <= '0;
      o_valid_q <= 1'b0;
      o_grad_q  <= '0;
      o_angle_q <= '0;
      o_eof_q   <= 1'b0;
    end else begin
      o_valid_q <= emit;
      o_eof_q   <= emit && last_out;
      if (emit) begin
        o_grad_q  <= win;
        o_angle_q <= ang_b_q;
        ocol_q    <= ocol_q == CW'(WIDTH-1) ? '0 : ocol_q + CW'(1);
        orow_q    <= ocol_q == CW'(WIDTH-1) ? (b_m ? '0 : orow_q + RW'(1)) : orow_q;
      end
      if (step) begin
        a_q     <= b_q;
        b_q     <= nc;
        ang_b_q <= mid_ang;
        col_q   <= col_end ? '0 : c_in + CW'(1);
        row_q   <= col_end ? (r_in == RW'(HEIGHT-1) ? '0 : r_in + RW'(1)) : r_in;
      end
      if (sof_take) begin
        state_q <= FILL;
        ocol_q  <= '0;
        orow_q  <= '0;
      end else if (take && state_q == FILL && fill_done) state_q <= RUN;
      else if (take && state_q == RUN && last_in) state_q <= FLUSH;
      else if (flush && last_out) begin
        state_q <= IDLE;
        col_q   <= '0;
        row_q   <= '0;
      end
    end
  end
endmodule

// File: tb/tb_grad_window_buf.sv
// tb_grad_window_buf: scoreboard bench for grad_window_buf at WIDTH=4, HEIGHT=3
module tb_grad_window_buf;
  logic clk = 0, rst = 1, vld = 0, sof = 0;
  logic [3:0] g = 0;
  logic [1:0] a = 0;
  logic rdy, ov, oe;
  logic [35:0] og;
  logic [1:0] oa;
  int checks = 0, errors = 0, lowcnt = 0;
  logic [38:0] q[$];
  logic [35:0] exp_w [12] = '{
    36'h000012056, 36'h000123567, 36'h000234678, 36'h000340780,
    36'h01205609A, 36'h1235679AB, 36'h234678ABC, 36'h340780BC0,
    36'h05609A000, 36'h5679AB000, 36'h678ABC000, 36'h780BC0000};

  always #5 clk = ~clk;

  grad_window_buf #(.DSIZE(4), .ANGSIZE(2), .WIDTH(4), .HEIGHT(3)) dut (
    .i_clk(clk), .i_rst(rst), .i_valid(vld), .i_sof(sof), .i_grad(g), .i_angle(a),
    .o_ready(rdy), .o_valid(ov), .o_grad(og), .o_angle(oa), .o_eof(oe));

  task automatic chk(string nm, logic [63:0] act, logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, expv);
    end
  endtask

  function automatic logic [38:0] expect_of(int m);
    return {m == 11, 2'(m % 4), exp_w[m]};
  endfunction

  always @(negedge clk) begin
    if (!rdy) lowcnt++;
    if (ov) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_window: got %h expected none", {oe, oa, og});
      end else chk("window{eof,angle,grad}", 64'({oe, oa, og}), 64'(q.pop_front()));
    end
  end

  task automatic beat(int n, bit s, int gaps);
    int t = 0;
    vld = 0;
    repeat (gaps) @(negedge clk);
    vld = 1; sof = s; g = 4'(n + 1); a = 2'(n % 4);
    while (!rdy && t < 100) begin @(negedge clk); t++; end
    if (t >= 100) chk("ready_timeout", 0, 1);
    if (n >= 5) q.push_back(expect_of(n - 5));
    if (n == 11) for (int m = 7; m < 12; m++) q.push_back(expect_of(m));
    @(negedge clk);
    vld = 0; sof = 0;
  endtask

  task automatic frame(int gapmax, int stop);
    for (int n = 0; n < stop; n++) beat(n, n == 0, gapmax > 0 ? int'($urandom_range(0, gapmax)) : 0);
  endtask

  task automatic finish_frame(string nm);
    repeat (10) @(negedge clk);
    chk({nm, "_ready_low_cycles"}, 64'(lowcnt), 5);
    chk({nm, "_queue_drained"}, 64'(q.size()), 0);
    chk({nm, "_ready_idle"}, 64'(rdy), 1);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("reset_valid", 64'(ov), 0);
    chk("reset_grad", 64'(og), 0);
    chk("reset_angle", 64'(oa), 0);
    chk("reset_eof", 64'(oe), 0);
    chk("reset_ready", 64'(rdy), 1);
    rst = 0;
    @(negedge clk);
    beat(1, 0, 0);
    beat(2, 0, 1);
    chk("idle_discard_ready", 64'(rdy), 1);
    lowcnt = 0;
    frame(0, 12);
    finish_frame("plain");
    lowcnt = 0;
    frame(3, 12);
    finish_frame("gapped");
    lowcnt = 0;
    frame(0, 6);
    frame(0, 12);
    finish_frame("restart");
    lowcnt = 0;
    frame(0, 12);
    for (int t = 0; t < 50 && lowcnt < 3; t++) begin @(negedge clk); #2; end
    rst = 1;
    #1;
    chk("midflush_rst_valid", 64'(ov), 0);
    chk("midflush_rst_grad", 64'(og), 0);
    chk("midflush_rst_angle", 64'(oa), 0);
    chk("midflush_rst_eof", 64'(oe), 0);
    chk("midflush_rst_ready", 64'(rdy), 1);
    chk("midflush_pending", 64'(q.size()), 3);
    q.delete();
    repeat (2) @(negedge clk);
    rst = 0;
    lowcnt = 0;
    frame(2, 12);
    finish_frame("after_reset");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
